muldiv_seq: RTL and testbench

- Iterative signed multiply/divide sequencer that replaces the combinational mult/div path feeding the HI/LO registers.
- Accepts a start pulse from the control unit and runs one radix-2 iteration per clock: shift-add for mult, restoring division for div.
- Applies a final sign-correction step, then presents a 64-bit result with a one-cycle write strobe for HI/LO.
- The control unit holds its multicycle FSM in a wait state until done.

---
 rtl/muldiv_seq.sv | 207 ++++++++++++++++++++
 tb/tb_muldiv_seq.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative signed multiply / divide sequencer feeding HI/LO.
// One radix-2 step per clock (shift-add for mult, restoring division for div),
// then a sign-fix cycle. The result is held in hi_out/lo_out with a one-cycle
// done/hi_lo_wr strobe.
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic             hi_lo_wr,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    // Latched operation context
    logic             op_r;
    logic             sign_a;
    logic             sign_b;
    logic             dz_r;
    logic [CW-1:0]    count;

    // opnd holds the multiplicand (mult) or the divisor (div) magnitude.
    // acc is the upper product half / partial remainder; mq is the
    // multiplier being consumed (mult) or the dividend turning into the
    // quotient (div).
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mq;

    // Combinational helpers
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic               b_zero;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   mul_acc_n;
    logic [WIDTH-1:0]   mul_mq_n;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff;
    logic [WIDTH-1:0]   div_acc_n;
    logic [WIDTH-1:0]   div_mq_n;
    logic [2*WIDTH-1:0] product;
    logic [2*WIDTH-1:0] product_s;
    logic [WIDTH-1:0]   quot_s;
    logic [WIDTH-1:0]   rem_s;

    // Operand magnitudes. A WIDTH-bit unsigned value already covers
    // 2^(WIDTH-1), so negating the most negative input still gives the
    // correct magnitude when read as unsigned.
    always_comb begin
        mag_a  = data_a[WIDTH-1] ? -data_a : data_a;
        mag_b  = data_b[WIDTH-1] ? -data_b : data_b;
        b_zero = (data_b == '0);
    end

    // One shift-add multiply step: conditional add into the upper half,
    // then shift the {carry, acc, mq} chain right by one.
    always_comb begin
        mul_sum   = {1'b0, acc} + (mq[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        mul_acc_n = mul_sum[WIDTH:1];
        mul_mq_n  = {mul_sum[0], mq[WIDTH-1:1]};
    end

    // One restoring-division step: shift the next dividend bit into the
    // partial remainder and keep the trial difference when it does not
    // go negative. The partial remainder is always below the divisor, so
    // the kept difference fits in WIDTH bits.
    always_comb begin
        div_shift = {acc, mq[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opnd});
        div_diff  = div_shift[WIDTH-1:0] - opnd;
        div_acc_n = div_ge ? div_diff : div_shift[WIDTH-1:0];
        div_mq_n  = {mq[WIDTH-2:0], div_ge};
    end

    // Sign correction of the unsigned results. The remainder follows the
    // dividend so that division truncates toward zero; the MIN / -1 case
    // naturally yields quotient 0x80..0 with remainder 0.
    always_comb begin
        product   = {acc, mq};
        product_s = (sign_a ^ sign_b) ? -product : product;
        quot_s    = (sign_a ^ sign_b) ? -mq : mq;
        rem_s     = sign_a ? -acc : acc;
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and strobe decode. Strobes come straight from the state
    // so that an asynchronous reset drops them immediately.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        div_zero   = 1'b0;
        hi_lo_wr   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (!op && b_zero) ? DONE : RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (count == '0) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                busy       = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                div_zero   = dz_r;
                hi_lo_wr   = !dz_r;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: latch operands on accept, iterate in RUN, publish the
    // signed result in FIX. hi_out/lo_out are untouched anywhere else.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_r   <= 1'b0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            dz_r   <= 1'b0;
            count  <= '0;
            opnd   <= '0;
            acc    <= '0;
            mq     <= '0;
            hi_out <= '0;
            lo_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_r   <= op;
                        sign_a <= data_a[WIDTH-1];
                        sign_b <= data_b[WIDTH-1];
                        dz_r   <= !op && b_zero;
                        count  <= CW'(WIDTH - 1);
                        acc    <= '0;
                        opnd   <= op ? mag_a : mag_b;
                        mq     <= op ? mag_b : mag_a;
                    end
                end
                RUN: begin
                    count <= count - CW'(1);
                    if (op_r) begin
                        acc <= mul_acc_n;
                        mq  <= mul_mq_n;
                    end else begin
                        acc <= div_acc_n;
                        mq  <= div_mq_n;
                    end
                end
                FIX: begin
                    if (op_r) begin
                        hi_out <= product_s[2*WIDTH-1:WIDTH];
                        lo_out <= product_s[WIDTH-1:0];
                    end else begin
                        hi_out <= rem_s;
                        lo_out <= quot_s;
                    end
                end
                DONE: begin
                    dz_r <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: randomized and directed checks of muldiv_seq against a
// plain-arithmetic reference model.
module tb_muldiv_seq;

    localparam int W       = 32;
    localparam int LAT     = W + 2;
    localparam int GAP     = W + 3;
    localparam int TIMEOUT = 200;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         op;
    logic [W-1:0] data_a;
    logic [W-1:0] data_b;
    logic         busy;
    logic         done;
    logic         div_zero;
    logic         hi_lo_wr;
    logic [W-1:0] hi_out;
    logic [W-1:0] lo_out;

    int errors   = 0;
    int checks   = 0;
    int done_cnt = 0;

    muldiv_seq #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .data_a   (data_a),
        .data_b   (data_b),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi_lo_wr (hi_lo_wr),
        .hi_out   (hi_out),
        .lo_out   (lo_out)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Count every cycle in which done is high
    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
    end

    // Reference model: signed 64-bit arithmetic, SV division truncates
    function automatic void model(input logic o, input logic [W-1:0] a,
                                  input logic [W-1:0] b,
                                  output logic [W-1:0] hi, output logic [W-1:0] lo);
        longint sa;
        longint sb;
        longint r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (o) begin
            r  = sa * sb;
            hi = r[63:32];
            lo = r[31:0];
        end else begin
            r  = sa / sb;
            lo = r[31:0];
            r  = sa % sb;
            hi = r[31:0];
        end
    endfunction

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Issue one operation and wait (bounded) for done. lat counts clock
    // edges from the accepting edge, inclusive.
    task automatic do_op(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output logic [W-1:0] hi, output logic [W-1:0] lo,
                         output logic dz, output logic wr, output logic bsy);
        @(negedge clk);
        op     = o;
        data_a = a;
        data_b = b;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        op     = ~o;
        data_a = $urandom;
        data_b = $urandom;
        lat    = 1;
        while (lat < TIMEOUT) begin
            @(negedge clk);
            if (done === 1'b1) break;
            lat++;
        end
        hi  = hi_out;
        lo  = lo_out;
        dz  = div_zero;
        wr  = hi_lo_wr;
        bsy = busy;
    endtask

    task automatic test_reset();
        reset  = 1'b0;
        start  = 1'b0;
        op     = 1'b0;
        data_a = '0;
        data_b = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, div_zero, hi_lo_wr} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_strobes: got %b expected 0000", {busy, done, div_zero, hi_lo_wr});
        end
        checks++;
        if ({hi_out, lo_out} !== 64'h0) begin
            errors++;
            $display("[TB] FAIL reset_hilo: got %h expected 0", {hi_out, lo_out});
        end
        reset = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL idle_no_start: got %b expected 00", {busy, done});
        end
    endtask

    task automatic test_directed();
        logic         ops [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [W-1:0] as  [6] = '{32'd7, 32'd17, 32'hFFFF_FFEF, 32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF};
        logic [W-1:0] bs  [6] = '{32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'd5, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        int           lat;
        logic [W-1:0] hi, lo, ehi, elo;
        logic         dz, wr, bsy;
        for (int i = 0; i < 6; i++) begin
            model(ops[i], as[i], bs[i], ehi, elo);
            do_op(ops[i], as[i], bs[i], lat, hi, lo, dz, wr, bsy);
            checks++;
            if (lat !== LAT) begin
                errors++;
                $display("[TB] FAIL dir%0d_latency: got %0d expected %0d", i, lat, LAT);
            end
            checks++;
            if ({hi, lo} !== {ehi, elo}) begin
                errors++;
                $display("[TB] FAIL dir%0d_result: got %h_%h expected %h_%h", i, hi, lo, ehi, elo);
            end
            checks++;
            if ({wr, dz, bsy} !== 3'b101) begin
                errors++;
                $display("[TB] FAIL dir%0d_strobes: got wr/dz/busy=%b expected 101", i, {wr, dz, bsy});
            end
            @(negedge clk);
            checks++;
            if ({busy, done, hi_lo_wr} !== 3'b000 || {hi_out, lo_out} !== {ehi, elo}) begin
                errors++;
                $display("[TB] FAIL dir%0d_after_done: got busy/done/wr=%b hilo=%h expected 000 hilo=%h",
                         i, {busy, done, hi_lo_wr}, {hi_out, lo_out}, {ehi, elo});
            end
        end
    endtask

    task automatic test_random();
        int           lat;
        logic         o;
        logic [W-1:0] a, b, hi, lo, ehi, elo;
        logic         dz, wr, bsy;
        for (int i = 0; i < 16; i++) begin
            o = 1'(i % 2);
            a = pick_operand();
            b = pick_operand();
            if (!o && b == '0) b = $urandom_range(1, 1000);
            model(o, a, b, ehi, elo);
            do_op(o, a, b, lat, hi, lo, dz, wr, bsy);
            checks++;
            if (lat !== LAT || {hi, lo} !== {ehi, elo} || {wr, dz} !== 2'b10) begin
                errors++;
                $display("[TB] FAIL rnd%0d op=%0d a=%h b=%h: got lat=%0d hilo=%h_%h wr/dz=%b expected lat=%0d hilo=%h_%h wr/dz=10",
                         i, o, a, b, lat, hi, lo, {wr, dz}, LAT, ehi, elo);
            end
        end
    endtask

    task automatic test_div_zero();
        int           lat;
        logic [W-1:0] hi, lo, ehi, elo;
        logic         dz, wr, bsy;
        model(1'b1, 32'd5, 32'hFFFF_FFF7, ehi, elo);
        do_op(1'b1, 32'd5, 32'hFFFF_FFF7, lat, hi, lo, dz, wr, bsy);
        do_op(1'b0, 32'd123, 32'd0, lat, hi, lo, dz, wr, bsy);
        checks++;
        if (lat !== 1) begin
            errors++;
            $display("[TB] FAIL dz_latency: got %0d expected 1", lat);
        end
        checks++;
        if ({dz, wr, bsy} !== 3'b101) begin
            errors++;
            $display("[TB] FAIL dz_strobes: got dz/wr/busy=%b expected 101", {dz, wr, bsy});
        end
        checks++;
        if ({hi, lo} !== {ehi, elo}) begin
            errors++;
            $display("[TB] FAIL dz_hilo_held: got %h_%h expected %h_%h", hi, lo, ehi, elo);
        end
        @(negedge clk);
        checks++;
        if ({busy, done, div_zero} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL dz_clear: got busy/done/dz=%b expected 000", {busy, done, div_zero});
        end
    endtask

    task automatic test_start_while_busy();
        int           lat;
        int           d0;
        logic [W-1:0] ehi, elo;
        model(1'b1, 32'd1234567, 32'hFFFF_FFA7, ehi, elo);
        #1 d0 = done_cnt;
        @(negedge clk);
        op     = 1'b1;
        data_a = 32'd1234567;
        data_b = 32'hFFFF_FFA7;
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 1;
        while (lat < TIMEOUT) begin
            @(negedge clk);
            if (done === 1'b1) break;
            if (lat == 10) begin
                start  = 1'b1;
                op     = 1'b0;
                data_a = 32'd99;
                data_b = 32'd0;
            end else begin
                start = 1'b0;
            end
            lat++;
        end
        start = 1'b0;
        checks++;
        if (lat !== LAT || {hi_out, lo_out} !== {ehi, elo} || div_zero !== 1'b0) begin
            errors++;
            $display("[TB] FAIL busy_start_ignored: got lat=%0d hilo=%h_%h dz=%b expected lat=%0d hilo=%h_%h dz=0",
                     lat, hi_out, lo_out, div_zero, LAT, ehi, elo);
        end
        repeat (40) @(negedge clk);
        #1;
        checks++;
        if (done_cnt - d0 !== 1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL busy_single_done: got %0d pulses busy=%b expected 1 pulse busy=0", done_cnt - d0, busy);
        end
    endtask

    task automatic test_reset_mid_op();
        int           lat;
        int           d0;
        logic [W-1:0] hi, lo;
        logic         dz, wr, bsy;
        @(negedge clk);
        op     = 1'b0;
        data_a = 32'hFFFF_FC18;
        data_b = 32'd7;
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (14) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if ({busy, done, hi_lo_wr} !== 3'b000 || {hi_out, lo_out} !== 64'h0) begin
            errors++;
            $display("[TB] FAIL midreset_clear: got busy/done/wr=%b hilo=%h expected 000 hilo=0",
                     {busy, done, hi_lo_wr}, {hi_out, lo_out});
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1 d0 = done_cnt;
        repeat (45) @(negedge clk);
        #1;
        checks++;
        if (done_cnt !== d0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_no_done: got %0d pulses busy=%b expected 0 pulses busy=0", done_cnt - d0, busy);
        end
        do_op(1'b1, 32'd6, 32'd7, lat, hi, lo, dz, wr, bsy);
        checks++;
        if (lat !== LAT || hi !== 32'd0 || lo !== 32'd42 || wr !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midreset_recover: got lat=%0d hilo=%h_%h wr=%b expected lat=%0d hilo=0_2a wr=1",
                     lat, hi, lo, wr, LAT);
        end
    endtask

    task automatic test_back_to_back();
        logic         ops [3];
        logic [W-1:0] as  [3];
        logic [W-1:0] bs  [3];
        logic [W-1:0] ehi, elo;
        int           gap;
        for (int i = 0; i < 3; i++) begin
            ops[i] = 1'($urandom_range(0, 1));
            as[i]  = $urandom;
            bs[i]  = $urandom | 32'h1;
        end
        @(negedge clk);
        op     = ops[0];
        data_a = as[0];
        data_b = bs[0];
        start  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            gap = 0;
            while (gap < TIMEOUT) begin
                @(negedge clk);
                gap++;
                if (done === 1'b1) break;
            end
            model(ops[i], as[i], bs[i], ehi, elo);
            checks++;
            if (gap !== ((i == 0) ? LAT : GAP) || {hi_out, lo_out} !== {ehi, elo}) begin
                errors++;
                $display("[TB] FAIL b2b%0d: got gap=%0d hilo=%h_%h expected gap=%0d hilo=%h_%h",
                         i, gap, hi_out, lo_out, (i == 0) ? LAT : GAP, ehi, elo);
            end
            if (i < 2) begin
                op     = ops[i+1];
                data_a = as[i+1];
                data_b = bs[i+1];
            end else begin
                start = 1'b0;
            end
        end
        repeat (3) @(negedge clk);
    endtask

    // Test sequence
    initial begin
        $display("[TB] muldiv_seq bench start");
        test_reset();
        test_directed();
        test_random();
        test_div_zero();
        test_start_while_busy();
        test_reset_mid_op();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
